// File: rtl/b_feed_pkg.sv
// Shared types for the B-operand feed sequencer.
// States, default sizes and the row bundle.
package b_feed_pkg;

  localparam int BITS_AB_D = 8;
  localparam int DIM_D     = 8;

  typedef enum logic [1:0] {
    LOAD,
    READY,
    FEED,
    FLUSH
  } state_t;

  typedef logic signed [DIM_D-1:0][BITS_AB_D-1:0] row_t;

endpackage

// File: rtl/b_row_buf.sv
// DIM-entry row register file with async row read.
// B_FEED_TRANSPOSE_EN adds an async column read port.
module b_row_buf
  import b_feed_pkg::*;
#(
  parameter int BITS_AB = BITS_AB_D,
  parameter int DIM     = DIM_D,
  parameter int AW      = 3
) (
  input  logic                             clk,
  input  logic                             we,
  input  logic [AW-1:0]                    waddr,
  input  logic signed [DIM-1:0][BITS_AB-1:0] wdata,
  input  logic [AW-1:0]                    raddr,
  output logic signed [DIM-1:0][BITS_AB-1:0] rdata
`ifdef B_FEED_TRANSPOSE_EN
  ,
  input  logic [AW-1:0]                    craddr,
  output logic signed [DIM-1:0][BITS_AB-1:0] cdata
`endif
);

  logic signed [DIM-1:0][BITS_AB-1:0] mem [DIM];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

`ifdef B_FEED_TRANSPOSE_EN
  // column c of the matrix lives at element DIM-1-c of every row
  always_comb begin
    cdata = '0;
    for (int j = 0; j < DIM; j++) begin
      cdata[DIM-1-j] = mem[j][DIM-1-int'(craddr)];
    end
  end
`endif

endmodule

// File: rtl/b_feed_ctrl.sv
// B-operand feed sequencer: buffer DIM rows, then feed + flush.
// Define B_FEED_TRANSPOSE_EN to emit the matrix column-by-column.
module b_feed_ctrl
  import b_feed_pkg::*;
#(
  parameter int BITS_AB   = BITS_AB_D,
  parameter int DIM       = DIM_D,
  parameter int FLUSH_CYC = 2*DIM-1
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic signed [DIM-1:0][BITS_AB-1:0] in_row,
  input  logic                             start,
  output logic                             busy,
  output logic                             done,
  output logic                             en_out,
  output logic signed [DIM-1:0][BITS_AB-1:0] Bout
);

  localparam int RCW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int FCW = (FLUSH_CYC > 0) ? $clog2(FLUSH_CYC+1) : 1;
  localparam logic [RCW-1:0] ROW_LAST = RCW'(DIM-1);
  localparam logic [FCW-1:0] FL_LAST  = FCW'(FLUSH_CYC);

  state_t         state;
  logic [RCW-1:0] row_cnt;
  logic [FCW-1:0] flush_cnt;
  logic           we;

  logic signed [DIM-1:0][BITS_AB-1:0] rd_row;
  logic signed [DIM-1:0][BITS_AB-1:0] feed_row;

  assign in_ready = (state == LOAD);
  assign we       = in_valid & in_ready;

`ifdef B_FEED_TRANSPOSE_EN
  logic signed [DIM-1:0][BITS_AB-1:0] col_row;

  b_row_buf #(
    .BITS_AB(BITS_AB),
    .DIM    (DIM),
    .AW     (RCW)
  ) u_buf (
    .clk   (clk),
    .we    (we),
    .waddr (row_cnt),
    .wdata (in_row),
    .raddr (row_cnt),
    .rdata (rd_row),
    .craddr(row_cnt),
    .cdata (col_row)
  );

  assign feed_row = col_row;
`else
  b_row_buf #(
    .BITS_AB(BITS_AB),
    .DIM    (DIM),
    .AW     (RCW)
  ) u_buf (
    .clk  (clk),
    .we   (we),
    .waddr(row_cnt),
    .wdata(in_row),
    .raddr(row_cnt),
    .rdata(rd_row)
  );

  assign feed_row = rd_row;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      row_cnt   <= '0;
      flush_cnt <= '0;
      en_out    <= 1'b0;
      Bout      <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      en_out <= 1'b0;
      done   <= 1'b0;
      Bout   <= '0;
      unique case (state)
        LOAD: begin
          if (we) begin
            if (row_cnt == ROW_LAST) begin
              row_cnt <= '0;
              state   <= READY;
            end else begin
              row_cnt <= row_cnt + 1'b1;
            end
          end
        end
        READY: begin
          if (start) begin
            state <= FEED;
            busy  <= 1'b1;
          end
        end
        FEED: begin
          en_out <= 1'b1;
          Bout   <= feed_row;
          if (row_cnt == ROW_LAST) begin
            row_cnt <= '0;
            state   <= FLUSH;
          end else begin
            row_cnt <= row_cnt + 1'b1;
          end
        end
        FLUSH: begin
          // zero rows drain the skew FIFOs; the terminal cycle only signals done
          if (flush_cnt == FL_LAST) begin
            done      <= 1'b1;
            busy      <= 1'b0;
            flush_cnt <= '0;
            row_cnt   <= '0;
            state     <= LOAD;
          end else begin
            en_out    <= 1'b1;
            flush_cnt <= flush_cnt + 1'b1;
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_b_feed_ctrl.sv
// Directed bench for b_feed_ctrl (DIM=8, FLUSH_CYC=15).
// Expected rows follow B_FEED_TRANSPOSE_EN when defined.
module tb_b_feed_ctrl;
  import b_feed_pkg::*;

  localparam int DIM  = 8;
  localparam int BITS = 8;
  localparam int FLC  = 2*DIM-1;
  localparam int W    = DIM*BITS;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic in_valid = 1'b0;
  logic start    = 1'b0;
  logic in_ready;
  logic busy;
  logic done;
  logic en_out;
  row_t in_row   = '0;
  row_t Bout;

  int checks   = 0;
  int failures = 0;
  row_t mat [DIM];

  b_feed_ctrl #(
    .BITS_AB  (BITS),
    .DIM      (DIM),
    .FLUSH_CYC(FLC)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_row  (in_row),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .en_out  (en_out),
    .Bout    (Bout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic row_t exp_row(input int c);
    row_t e;
    e = '0;
`ifdef B_FEED_TRANSPOSE_EN
    for (int j = 0; j < DIM; j++) e[DIM-1-j] = mat[j][DIM-1-c];
`else
    e = mat[c];
`endif
    return e;
  endfunction

  task automatic load(input bit bubbles, input int lo, input int hi);
    for (int r = lo; r <= hi; r++) begin
      if (bubbles) begin
        in_valid = 1'b0;
        in_row   = '1;
        tick;
      end
      in_valid = 1'b1;
      in_row   = mat[r];
      chk("load_rdy", in_ready, 1);
      tick;
    end
    in_valid = 1'b0;
  endtask

  task automatic feed(input int late, input bit hold_valid);
    int en_cnt;
    en_cnt   = 0;
    start    = 1'b1;
    in_valid = hold_valid;
    in_row   = '1;
    tick;
    start = 1'b0;
    chk("busy_t", busy, 1);
    chk("en_t", en_out, 0);
    for (int c = 1; c <= DIM+FLC+1; c++) begin
      start    = (c == late);
      in_valid = hold_valid && (c <= DIM+FLC);
      chk("feed_rdy", in_ready, 0);
      tick;
      if (en_out) en_cnt++;
      if (c <= DIM) chk("row", Bout, exp_row(c-1));
      else if (c <= DIM+FLC) chk("zero", Bout, 0);
      chk("done", done, (c == DIM+FLC+1));
    end
    start    = 1'b0;
    in_valid = 1'b0;
    chk("en_cnt", en_cnt, DIM+FLC);
    chk("end_rdy", in_ready, 1);
    chk("end_busy", busy, 0);
    chk("end_en", en_out, 0);
    tick;
    chk("done_pulse", done, 0);
  endtask

  initial begin
    int hits;

    // reset
    rst_n = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
    tick;
    chk("rst_rdy", in_ready, 1);
    chk("rst_en", en_out, 0);
    chk("rst_bout", Bout, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);

    // basic load and feed
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) mat[r][k] = 8'(r*8+k);
    load(1'b0, 0, DIM-1);
    chk("full_rdy", in_ready, 0);
    feed(-1, 1'b0);

    // bubbles, then valid held through READY and start cycle
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) mat[r][k] = 8'(r*8+k) ^ 8'h5a;
    load(1'b1, 0, DIM-1);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_row   = '1;
      tick;
      chk("ready_rdy", in_ready, 0);
    end
    feed(-1, 1'b1);

    // early start during LOAD, late start during FEED
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) mat[r][k] = 8'(200 - r*16 - k);
    load(1'b0, 0, 2);
    start = 1'b1;
    tick;
    start = 1'b0;
    chk("early_busy", busy, 0);
    load(1'b0, 3, DIM-1);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("idle_busy", busy, 0);
      chk("idle_en", en_out, 0);
    end
    feed(3, 1'b0);
    hits = 0;
    for (int i = 0; i < 4; i++) begin
      tick;
      if (en_out || busy) hits++;
    end
    chk("no_refeed", hits, 0);

    // reset in the middle of FEED
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++) mat[r][k] = 8'(r*3 + k*17);
    load(1'b0, 0, DIM-1);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("pre_rst_row", Bout, exp_row(2));
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    chk("mrst_en", en_out, 0);
    chk("mrst_bout", Bout, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_rdy", in_ready, 1);
    hits = 0;
    for (int i = 0; i < 30; i++) begin
      tick;
      if (done || en_out) hits++;
    end
    chk("mrst_quiet", hits, 0);
    load(1'b0, 0, DIM-1);
    chk("mrst_full", in_ready, 0);
    feed(-1, 1'b0);

    // signed extremes
    for (int r = 0; r < DIM; r++)
      for (int k = 0; k < DIM; k++)
        mat[r][k] = ((r + k) % 2 == 1) ? 8'h80 : 8'h7f;
    mat[0][DIM-1] = 8'h80;
    load(1'b0, 0, DIM-1);
    feed(-1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
